gb_frame_ctrl: RTL and testbench

Frame-level controller for the gray-balance pipeline. It snoops the Avalon-ST video stream entering the gain datapath and classifies packets by their header beat. For video packets it accumulates per-channel R/G/B sums and a pixel count. It commits shadowed gain and bypass settings to the datapath only at video-frame start, so a frame is never processed with mixed gains.

---
 rtl/gb_pkg.sv | 14 +
 rtl/gb_chan_accum.sv | 48 ++++
 rtl/gb_frame_ctrl.sv | 165 ++++++++++++++++
 tb/tb_gb_frame_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_pkg.sv
// rtl/gb_pkg.sv - shared constants and state encoding for the gray-balance frame controller
package gb_pkg;

    localparam logic [3:0] PKT_VIDEO   = 4'h0;
    localparam logic [3:0] PKT_CTRL    = 4'hF;
    localparam int         GB_GAIN_ONE = 256;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_VIDEO = 2'd1,
        S_SKIP  = 2'd2
    } gb_state_e;

endpackage

// File: rtl/gb_chan_accum.sv
// rtl/gb_chan_accum.sv - saturating per-channel accumulator with clear and sticky overflow
module gb_chan_accum #(
    parameter int DW = 8,
    parameter int SW = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_add,
    input  logic [DW-1:0] i_din,
    output logic [SW-1:0] o_sum_nxt,
    output logic          o_ovf_nxt
);

    logic [SW-1:0] r_sum;
    logic          r_ovf;
    logic [SW:0]   w_add;

    // Next-state values are exported so the parent can latch a frame total
    // on the same edge that absorbs the final pixel.
    always_comb begin
        w_add     = {1'b0, r_sum} + (SW+1)'(i_din);
        o_sum_nxt = r_sum;
        o_ovf_nxt = r_ovf;
        if (i_clr) begin
            o_sum_nxt = '0;
            o_ovf_nxt = 1'b0;
        end else if (i_add) begin
            if (w_add[SW]) begin
                o_sum_nxt = '1;
                o_ovf_nxt = 1'b1;
            end else begin
                o_sum_nxt = w_add[SW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_sum <= o_sum_nxt;
            r_ovf <= o_ovf_nxt;
        end
    end

endmodule

// File: rtl/gb_frame_ctrl.sv
// rtl/gb_frame_ctrl.sv - packet classifier, frame statistics and frame-aligned gain commit
module gb_frame_ctrl
    import gb_pkg::*;
#(
    parameter int CH_WIDTH   = 8,
    parameter int CNT_WIDTH  = 22,
    parameter int GAIN_WIDTH = 10,
    parameter int SUM_WIDTH  = CH_WIDTH + CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3*CH_WIDTH-1:0] din_data,
    input  logic                  din_valid,
    input  logic                  din_ready,
    input  logic                  din_sop,
    input  logic                  din_eop,
    input  logic [GAIN_WIDTH-1:0] cfg_gain_r,
    input  logic [GAIN_WIDTH-1:0] cfg_gain_g,
    input  logic [GAIN_WIDTH-1:0] cfg_gain_b,
    input  logic                  cfg_bypass,
    input  logic                  cfg_wr,
    output logic [GAIN_WIDTH-1:0] gain_r,
    output logic [GAIN_WIDTH-1:0] gain_g,
    output logic [GAIN_WIDTH-1:0] gain_b,
    output logic                  bypass,
    output logic                  gain_commit,
    output logic                  cfg_pending,
    output logic [SUM_WIDTH-1:0]  stat_sum_r,
    output logic [SUM_WIDTH-1:0]  stat_sum_g,
    output logic [SUM_WIDTH-1:0]  stat_sum_b,
    output logic [CNT_WIDTH-1:0]  stat_pix_cnt,
    output logic                  stat_valid,
    output logic                  stat_ovf,
    output logic                  frame_err,
    output logic                  busy
);

    localparam logic [GAIN_WIDTH-1:0] GAIN_ONE = GAIN_WIDTH'(GB_GAIN_ONE);

    gb_state_e             r_state;
    logic [GAIN_WIDTH-1:0] r_sh_gain_r, r_sh_gain_g, r_sh_gain_b;
    logic                  r_sh_bypass;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_cnt_ovf;

    logic                  w_beat, w_hdr, w_is_video, w_clr, w_pix, w_latch, w_commit;
    logic [CNT_WIDTH-1:0]  w_cnt_nxt;
    logic                  w_cnt_ovf_nxt;
    logic [SUM_WIDTH-1:0]  w_sum_r_nxt, w_sum_g_nxt, w_sum_b_nxt;
    logic                  w_ovf_r_nxt, w_ovf_g_nxt, w_ovf_b_nxt;

    assign w_beat     = din_valid & din_ready;
    assign w_hdr      = w_beat & din_sop;
    assign w_is_video = (din_data[3:0] == PKT_VIDEO);
    assign w_clr      = w_hdr & w_is_video;
    assign w_pix      = w_beat & ~din_sop & (r_state == S_VIDEO);
    assign w_commit   = w_clr & cfg_pending;
    // A single-beat video packet reports an empty frame, so it latches too.
    assign w_latch    = (w_pix | w_clr) & din_eop;

    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_cnt_ovf_nxt = r_cnt_ovf;
        if (w_clr) begin
            w_cnt_nxt     = '0;
            w_cnt_ovf_nxt = 1'b0;
        end else if (w_pix) begin
            if (&r_cnt) begin
                w_cnt_ovf_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    gb_chan_accum #(.DW(CH_WIDTH), .SW(SUM_WIDTH)) u_acc_r (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_add(w_pix),
        .i_din(din_data[3*CH_WIDTH-1 -: CH_WIDTH]),
        .o_sum_nxt(w_sum_r_nxt), .o_ovf_nxt(w_ovf_r_nxt)
    );

    gb_chan_accum #(.DW(CH_WIDTH), .SW(SUM_WIDTH)) u_acc_g (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_add(w_pix),
        .i_din(din_data[2*CH_WIDTH-1 -: CH_WIDTH]),
        .o_sum_nxt(w_sum_g_nxt), .o_ovf_nxt(w_ovf_g_nxt)
    );

    gb_chan_accum #(.DW(CH_WIDTH), .SW(SUM_WIDTH)) u_acc_b (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_add(w_pix),
        .i_din(din_data[CH_WIDTH-1:0]),
        .o_sum_nxt(w_sum_b_nxt), .o_ovf_nxt(w_ovf_b_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_sh_gain_r  <= GAIN_ONE;
            r_sh_gain_g  <= GAIN_ONE;
            r_sh_gain_b  <= GAIN_ONE;
            r_sh_bypass  <= 1'b0;
            r_cnt        <= '0;
            r_cnt_ovf    <= 1'b0;
            gain_r       <= GAIN_ONE;
            gain_g       <= GAIN_ONE;
            gain_b       <= GAIN_ONE;
            bypass       <= 1'b0;
            gain_commit  <= 1'b0;
            cfg_pending  <= 1'b0;
            stat_sum_r   <= '0;
            stat_sum_g   <= '0;
            stat_sum_b   <= '0;
            stat_pix_cnt <= '0;
            stat_valid   <= 1'b0;
            stat_ovf     <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_cnt_ovf   <= w_cnt_ovf_nxt;
            gain_commit <= w_commit;
            stat_valid  <= w_latch;
            frame_err   <= w_hdr & (r_state != S_IDLE);

            if (w_commit) begin
                gain_r <= r_sh_gain_r;
                gain_g <= r_sh_gain_g;
                gain_b <= r_sh_gain_b;
                bypass <= r_sh_bypass;
            end

            // A write coinciding with a commit lands in the shadow and stays pending.
            if (cfg_wr) begin
                r_sh_gain_r <= cfg_gain_r;
                r_sh_gain_g <= cfg_gain_g;
                r_sh_gain_b <= cfg_gain_b;
                r_sh_bypass <= cfg_bypass;
                cfg_pending <= 1'b1;
            end else if (w_commit) begin
                cfg_pending <= 1'b0;
            end

            if (w_latch) begin
                stat_sum_r   <= w_sum_r_nxt;
                stat_sum_g   <= w_sum_g_nxt;
                stat_sum_b   <= w_sum_b_nxt;
                stat_pix_cnt <= w_cnt_nxt;
                stat_ovf     <= w_cnt_ovf_nxt | w_ovf_r_nxt | w_ovf_g_nxt | w_ovf_b_nxt;
            end

            if (w_hdr) begin
                if (din_eop) begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end else begin
                    r_state <= w_is_video ? S_VIDEO : S_SKIP;
                    busy    <= 1'b1;
                end
            end else if (w_beat && din_eop && r_state != S_IDLE) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gb_frame_ctrl.sv
// tb/tb_gb_frame_ctrl.sv - directed self-checking bench for gb_frame_ctrl
module tb_gb_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] din_data = '0;
    logic        din_valid = 1'b0;
    logic        din_ready = 1'b1;
    logic        din_sop = 1'b0;
    logic        din_eop = 1'b0;
    logic [9:0]  cfg_gain_r = '0, cfg_gain_g = '0, cfg_gain_b = '0;
    logic        cfg_bypass = 1'b0;
    logic        cfg_wr = 1'b0;

    logic [9:0]  gain_r, gain_g, gain_b;
    logic        bypass, gain_commit, cfg_pending;
    logic [29:0] stat_sum_r, stat_sum_g, stat_sum_b;
    logic [21:0] stat_pix_cnt;
    logic        stat_valid, stat_ovf, frame_err, busy;

    logic [9:0]  s_gain_r, s_gain_g, s_gain_b;
    logic        s_bypass, s_gain_commit, s_cfg_pending;
    logic [11:0] s_sum_r, s_sum_g, s_sum_b;
    logic [3:0]  s_pix_cnt;
    logic        s_stat_valid, s_stat_ovf, s_frame_err, s_busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gb_frame_ctrl dut (
        .clk(clk), .rst_n(rst_n), .din_data(din_data), .din_valid(din_valid),
        .din_ready(din_ready), .din_sop(din_sop), .din_eop(din_eop),
        .cfg_gain_r(cfg_gain_r), .cfg_gain_g(cfg_gain_g), .cfg_gain_b(cfg_gain_b),
        .cfg_bypass(cfg_bypass), .cfg_wr(cfg_wr),
        .gain_r(gain_r), .gain_g(gain_g), .gain_b(gain_b), .bypass(bypass),
        .gain_commit(gain_commit), .cfg_pending(cfg_pending),
        .stat_sum_r(stat_sum_r), .stat_sum_g(stat_sum_g), .stat_sum_b(stat_sum_b),
        .stat_pix_cnt(stat_pix_cnt), .stat_valid(stat_valid), .stat_ovf(stat_ovf),
        .frame_err(frame_err), .busy(busy)
    );

    gb_frame_ctrl #(.CNT_WIDTH(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .din_data(din_data), .din_valid(din_valid),
        .din_ready(din_ready), .din_sop(din_sop), .din_eop(din_eop),
        .cfg_gain_r(cfg_gain_r), .cfg_gain_g(cfg_gain_g), .cfg_gain_b(cfg_gain_b),
        .cfg_bypass(cfg_bypass), .cfg_wr(cfg_wr),
        .gain_r(s_gain_r), .gain_g(s_gain_g), .gain_b(s_gain_b), .bypass(s_bypass),
        .gain_commit(s_gain_commit), .cfg_pending(s_cfg_pending),
        .stat_sum_r(s_sum_r), .stat_sum_g(s_sum_g), .stat_sum_b(s_sum_b),
        .stat_pix_cnt(s_pix_cnt), .stat_valid(s_stat_valid), .stat_ovf(s_stat_ovf),
        .frame_err(s_frame_err), .busy(s_busy)
    );

    function automatic logic [23:0] px(input int r, input int g, input int b);
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    // Presents one beat at a falling edge; returns on the following falling edge.
    task automatic beat(input logic [23:0] d, input logic sop, input logic eop);
        din_data  = d;
        din_sop   = sop;
        din_eop   = eop;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    // Same beat but held one cycle with ready low first.
    task automatic sbeat(input logic [23:0] d, input logic sop, input logic eop);
        din_data  = d;
        din_sop   = sop;
        din_eop   = eop;
        din_valid = 1'b1;
        din_ready = 1'b0;
        @(negedge clk);
        din_ready = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_stats(input string nm, input int r, input int g, input int b,
                             input int cnt, input logic ovf);
        tests++;
        if (stat_sum_r !== 30'(r) || stat_sum_g !== 30'(g) || stat_sum_b !== 30'(b) ||
            stat_pix_cnt !== 22'(cnt) || stat_ovf !== ovf) begin
            fails++;
            $display("FAIL %s: got sums %0d/%0d/%0d cnt %0d ovf %0b, expected %0d/%0d/%0d cnt %0d ovf %0b",
                     nm, stat_sum_r, stat_sum_g, stat_sum_b, stat_pix_cnt, stat_ovf,
                     r, g, b, cnt, ovf);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        tests++;
        if (gain_r !== 10'd256 || gain_g !== 10'd256 || gain_b !== 10'd256 || bypass !== 1'b0) begin
            fails++;
            $display("FAIL reset_gains: got %0d/%0d/%0d byp %0b, expected 256/256/256 byp 0",
                     gain_r, gain_g, gain_b, bypass);
        end
        tests++;
        if ({gain_commit, cfg_pending, stat_valid, stat_ovf, frame_err, busy} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %06b, expected 000000",
                     {gain_commit, cfg_pending, stat_valid, stat_ovf, frame_err, busy});
        end
        rst_n = 1'b1;
        idle(1);
        chk_stats("reset_stats", 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_basic_frame();
        beat(24'h000000, 1'b1, 1'b0);
        tests++;
        if (busy !== 1'b1 || gain_commit !== 1'b0) begin
            fails++;
            $display("FAIL basic_hdr: got busy %0b commit %0b, expected busy 1 commit 0", busy, gain_commit);
        end
        beat(px(10, 20, 30), 1'b0, 1'b0);
        beat(px(1, 2, 3), 1'b0, 1'b0);
        beat(px(5, 5, 5), 1'b0, 1'b1);
        tests++;
        if (stat_valid !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_valid: got stat_valid %0b busy %0b, expected 1 0", stat_valid, busy);
        end
        chk_stats("basic_stats", 16, 27, 38, 3, 1'b0);
        idle(1);
        tests++;
        if (stat_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_pulse: got stat_valid %0b, expected 0", stat_valid);
        end
    endtask

    task automatic test_ctrl_stall();
        beat(24'h123456, 1'b0, 1'b1);
        tests++;
        if (busy !== 1'b0 || stat_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_nonsop: got busy %0b stat_valid %0b, expected 0 0", busy, stat_valid);
        end
        beat(24'h00000F, 1'b1, 1'b0);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL ctrl_busy: got %0b, expected 1", busy);
        end
        beat(px(200, 200, 200), 1'b0, 1'b0);
        beat(px(9, 9, 9), 1'b0, 1'b1);
        tests++;
        if (stat_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL ctrl_end: got stat_valid %0b busy %0b, expected 0 0", stat_valid, busy);
        end
        chk_stats("ctrl_keeps_stats", 16, 27, 38, 3, 1'b0);
        sbeat(24'h000000, 1'b1, 1'b0);
        sbeat(px(10, 20, 30), 1'b0, 1'b0);
        sbeat(px(1, 2, 3), 1'b0, 1'b0);
        sbeat(px(5, 5, 5), 1'b0, 1'b1);
        tests++;
        if (stat_valid !== 1'b1) begin
            fails++;
            $display("FAIL stall_valid: got %0b, expected 1", stat_valid);
        end
        chk_stats("stall_stats", 16, 27, 38, 3, 1'b0);
        idle(1);
    endtask

    task automatic test_commit();
        beat(24'h000000, 1'b1, 1'b0);
        beat(px(4, 4, 4), 1'b0, 1'b0);
        cfg_gain_r = 10'd300; cfg_gain_g = 10'd256; cfg_gain_b = 10'd200; cfg_bypass = 1'b1;
        cfg_wr = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
        tests++;
        if (cfg_pending !== 1'b1 || gain_r !== 10'd256 || gain_b !== 10'd256 || bypass !== 1'b0) begin
            fails++;
            $display("FAIL commit_hold: got pend %0b gains %0d/%0d byp %0b, expected 1 256/256 0",
                     cfg_pending, gain_r, gain_b, bypass);
        end
        beat(px(4, 4, 4), 1'b0, 1'b1);
        tests++;
        if (gain_r !== 10'd256 || gain_commit !== 1'b0) begin
            fails++;
            $display("FAIL commit_eop: got gain_r %0d commit %0b, expected 256 0", gain_r, gain_commit);
        end
        beat(24'h000000, 1'b1, 1'b0);
        tests++;
        if (gain_r !== 10'd300 || gain_g !== 10'd256 || gain_b !== 10'd200 || bypass !== 1'b1 ||
            gain_commit !== 1'b1 || cfg_pending !== 1'b0) begin
            fails++;
            $display("FAIL commit_edge: got %0d/%0d/%0d byp %0b commit %0b pend %0b, expected 300/256/200 1 1 0",
                     gain_r, gain_g, gain_b, bypass, gain_commit, cfg_pending);
        end
        cfg_gain_r = 10'd100; cfg_gain_g = 10'd101; cfg_gain_b = 10'd102; cfg_bypass = 1'b0;
        cfg_wr = 1'b1;
        @(negedge clk);
        cfg_wr = 1'b0;
        tests++;
        if (gain_commit !== 1'b0 || gain_r !== 10'd300) begin
            fails++;
            $display("FAIL commit_pulse: got commit %0b gain_r %0d, expected 0 300", gain_commit, gain_r);
        end
        beat(px(1, 1, 1), 1'b0, 1'b1);
        cfg_gain_r = 10'd400; cfg_gain_g = 10'd401; cfg_gain_b = 10'd402; cfg_bypass = 1'b1;
        cfg_wr = 1'b1;
        beat(24'h000000, 1'b1, 1'b0);
        cfg_wr = 1'b0;
        tests++;
        if (gain_r !== 10'd100 || gain_g !== 10'd101 || gain_b !== 10'd102 || bypass !== 1'b0 ||
            gain_commit !== 1'b1 || cfg_pending !== 1'b1) begin
            fails++;
            $display("FAIL commit_wr_same: got %0d/%0d/%0d byp %0b commit %0b pend %0b, expected 100/101/102 0 1 1",
                     gain_r, gain_g, gain_b, bypass, gain_commit, cfg_pending);
        end
        beat(px(1, 1, 1), 1'b0, 1'b1);
        idle(1);
    endtask

    task automatic test_abort();
        beat(24'h000000, 1'b1, 1'b0);
        tests++;
        if (gain_r !== 10'd400 || bypass !== 1'b1 || cfg_pending !== 1'b0) begin
            fails++;
            $display("FAIL abort_commit: got gain_r %0d byp %0b pend %0b, expected 400 1 0",
                     gain_r, bypass, cfg_pending);
        end
        beat(px(9, 9, 9), 1'b0, 1'b1);
        chk_stats("abort_prev", 9, 9, 9, 1, 1'b0);
        beat(24'h000000, 1'b1, 1'b0);
        beat(px(1, 1, 1), 1'b0, 1'b0);
        beat(px(2, 2, 2), 1'b0, 1'b0);
        beat(24'h000000, 1'b1, 1'b0);
        tests++;
        if (frame_err !== 1'b1 || stat_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_err: got err %0b stat_valid %0b busy %0b, expected 1 0 1",
                     frame_err, stat_valid, busy);
        end
        chk_stats("abort_retain", 9, 9, 9, 1, 1'b0);
        beat(px(3, 4, 5), 1'b0, 1'b1);
        tests++;
        if (frame_err !== 1'b0 || stat_valid !== 1'b1) begin
            fails++;
            $display("FAIL abort_next: got err %0b stat_valid %0b, expected 0 1", frame_err, stat_valid);
        end
        chk_stats("abort_fresh", 3, 4, 5, 1, 1'b0);
        beat(24'h000000, 1'b1, 1'b1);
        tests++;
        if (stat_valid !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_beat: got stat_valid %0b busy %0b, expected 1 0", stat_valid, busy);
        end
        chk_stats("single_beat_stats", 0, 0, 0, 0, 1'b0);
        idle(1);
    endtask

    task automatic test_saturation();
        beat(24'h000000, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) beat(24'hFFFFFF, 1'b0, (i == 19));
        tests++;
        if (s_stat_valid !== 1'b1 || s_pix_cnt !== 4'd15 || s_stat_ovf !== 1'b1 ||
            s_sum_r !== 12'd4095 || s_sum_g !== 12'd4095 || s_sum_b !== 12'd4095) begin
            fails++;
            $display("FAIL sat_small: got valid %0b cnt %0d ovf %0b sums %0d/%0d/%0d, expected 1 15 1 4095/4095/4095",
                     s_stat_valid, s_pix_cnt, s_stat_ovf, s_sum_r, s_sum_g, s_sum_b);
        end
        chk_stats("sat_wide", 5100, 5100, 5100, 20, 1'b0);
        idle(1);
    endtask

    task automatic test_reset_mid();
        beat(24'h000000, 1'b1, 1'b0);
        beat(px(7, 7, 7), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || gain_r !== 10'd256 || bypass !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_async: got busy %0b gain_r %0d byp %0b, expected 0 256 0",
                     busy, gain_r, bypass);
        end
        @(negedge clk);
        rst_n = 1'b1;
        beat(px(7, 7, 7), 1'b0, 1'b1);
        tests++;
        if (stat_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_stat: got stat_valid %0b busy %0b, expected 0 0", stat_valid, busy);
        end
        chk_stats("reset_mid_clear", 0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_ctrl_stall();
        test_commit();
        test_abort();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
